// File: rtl/pipo_share_arb.sv
// pipo_share_arb: round-robin arbiter feeding a single-entry holding register.
// NREQ producers compete for one WIDTH-bit slot. The held word is tagged with
// the index of its writer and drained by one consumer over valid/ready.
module pipo_share_arb #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic [15:0]           xfer_cnt
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_data;
  logic [IDW-1:0]     r_id;
  logic [IDW-1:0]     r_ptr;
  logic [15:0]        r_xfer_cnt;

  logic               w_load_open;
  logic               w_pop;
  logic               w_hit;
  logic [2*NREQ-1:0]  w_req_rot;
  logic [IDW:0]       w_sum;
  logic [IDW-1:0]     w_gnt_id;
  logic [IDW-1:0]     w_ptr_nxt;
  logic [NREQ-1:0]    w_gnt;
  logic [WIDTH-1:0]   w_gnt_word;

  // The slot can take a new word when empty, or when the current word leaves
  // this cycle. Gating with rst_n keeps gnt low throughout reset.
  assign w_load_open = rst_n && !flush && ((r_state == S_EMPTY) || out_ready);
  assign w_pop       = (r_state == S_FULL) && out_ready && !flush;

  // Rotate requests so bit 0 is the requester at ptr; the lowest set bit wins.
  assign w_req_rot = {req, req} >> r_ptr;

  // Find the first requester at or after ptr and translate back to its index
  always_comb begin
    w_hit    = 1'b0;
    w_sum    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!w_hit && w_req_rot[j]) begin
        w_hit = 1'b1;
        w_sum = {1'b0, r_ptr} + (IDW+1)'(j);
      end
    end
    if (w_sum >= (IDW+1)'(NREQ)) begin
      w_sum = w_sum - (IDW+1)'(NREQ);
    end
    w_hit    = w_hit && w_load_open;
    w_gnt_id = w_sum[IDW-1:0];
  end

  // One-hot grant, the granted word, and the pointer that follows the winner
  always_comb begin
    w_gnt      = '0;
    w_gnt_word = '0;
    w_ptr_nxt  = r_ptr;
    if (w_hit) begin
      w_gnt     = NREQ'(1) << w_gnt_id;
      w_ptr_nxt = (w_gnt_id == IDW'(NREQ-1)) ? '0 : (w_gnt_id + IDW'(1));
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_word = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state: flush empties, a grant fills, an unreplaced pop empties
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_hit) w_state_nxt = S_FULL;
      S_FULL: begin
        if (flush)          w_state_nxt = S_EMPTY;
        else if (w_hit)     w_state_nxt = S_FULL;
        else if (out_ready) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // State, held word, round-robin pointer and transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_data     <= '0;
      r_id       <= '0;
      r_ptr      <= '0;
      r_xfer_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hit) begin
        r_data <= w_gnt_word;
        r_id   <= w_gnt_id;
        r_ptr  <= w_ptr_nxt;
      end
      if (w_pop) begin
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
    end
  end

  assign gnt       = w_gnt;
  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_data;
  assign out_id    = r_id;
  assign xfer_cnt  = r_xfer_cnt;

endmodule
